mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a shared single-port memory.
// Alternating priority on ties, per-access timeout abort, all outputs registered.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  // Abort fires in the BUSY cycle where the count would reach TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              i_err_q, i_err_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic i_elig, d_elig, grant_i, grant_d, done, abort;

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    i_err_d     = i_err_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = d_err_q;
    // A port being acked this cycle may still show its old request.
    i_elig      = i_req & ~i_ack_q;
    d_elig      = d_req & ~d_ack_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_i = i_elig & (~d_elig | last_d_q);
        grant_d = d_elig & ~grant_i;
        if (grant_i) begin
          state_d     = BUSY_I;
          last_d_d    = 1'b0;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          last_d_d    = 1'b1;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end
      end
      BUSY_I, BUSY_D: begin
        done  = mem_ack & mem_req_q;
        abort = ~done & (cnt_q == CNT_LAST);
        if (done | abort) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = abort ? '0 : mem_rdata;
            i_err_d   = abort;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = abort ? '0 : mem_rdata;
            d_err_d   = abort;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      i_err_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      i_err_q     <= i_err_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign i_err     = i_err_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder model, grant/ack scoreboards,
// a single-transaction vector table and hand sequences for ties, timeout and reset.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model_rdata(input logic [AW-1:0] a);
    return a ^ 32'h2002_0041;
  endfunction

  // Memory model: ack after ack_delay cycles of mem_req (-1 = never).
  int ack_delay = 0;
  bit stray_ack = 1'b0;
  int wait_n = 0;
  always @(negedge clk_in) begin
    #1;
    if (mem_req === 1'b1) begin
      if (ack_delay >= 0 && wait_n == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = model_rdata(mem_addr);
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_0000 | 32'(wait_n);
      end
      wait_n++;
    end else begin
      mem_ack   = stray_ack;
      mem_rdata = 32'h5A5A_5A5A;
      wait_n    = 0;
    end
  end

  typedef struct { logic [DW-1:0] rdata; logic err; } exp_t;
  exp_t i_q[$];
  exp_t d_q[$];
  bit   grant_q[$];

  task automatic push_exp(input bit port_d, input logic [DW-1:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    if (port_d) d_q.push_back(e);
    else        i_q.push_back(e);
  endtask

  // Monitor: grant contents/stability and ack payloads against the scoreboards.
  logic          prev_req = 1'b0;
  bit            g_valid = 1'b0;
  bit            g_port;
  logic [AW-1:0] g_addr;
  logic          g_we;
  logic [DW-1:0] g_wdata;
  exp_t          e_mon;
  always @(negedge clk_in) begin
    if (mem_req === 1'b1 && prev_req !== 1'b1) begin
      if (grant_q.size() == 0) begin
        g_valid = 1'b0;
        chk("unexpected_grant", mem_req, 1'b0);
      end else begin
        g_valid = 1'b1;
        g_port  = grant_q.pop_front();
        g_addr  = g_port ? d_addr : i_addr;
        g_we    = g_port ? d_we : 1'b0;
        g_wdata = d_wdata;
      end
    end
    if (mem_req === 1'b1 && g_valid) begin
      chk(g_port ? "mem_addr_d" : "mem_addr_i", mem_addr, g_addr);
      chk(g_port ? "mem_we_d" : "mem_we_i", mem_we, g_we);
      if (g_port) chk("mem_wdata_d", mem_wdata, g_wdata);
    end
    prev_req = mem_req;
    if (i_ack === 1'b1) begin
      chk("ack_exclusive", d_ack, 1'b0);
      if (i_q.size() == 0) chk("i_unexpected_ack", i_ack, 1'b0);
      else begin
        e_mon = i_q.pop_front();
        chk("i_rdata", i_rdata, e_mon.rdata);
        chk("i_err", i_err, e_mon.err);
      end
    end
    if (d_ack === 1'b1) begin
      if (d_q.size() == 0) chk("d_unexpected_ack", d_ack, 1'b0);
      else begin
        e_mon = d_q.pop_front();
        chk("d_rdata", d_rdata, e_mon.rdata);
        chk("d_err", d_err, e_mon.err);
      end
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #2;
  endtask

  task automatic wait_ack(input bit port_d, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      tick();
      if ((port_d ? d_ack : i_ack) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk(port_d ? "d_ack_wait" : "i_ack_wait", port_d ? d_ack : i_ack, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, '0);
    chk({tag, "_mem_wdata"}, mem_wdata, '0);
    chk({tag, "_i_ack"}, i_ack, 1'b0);
    chk({tag, "_i_rdata"}, i_rdata, '0);
    chk({tag, "_i_err"}, i_err, 1'b0);
    chk({tag, "_d_ack"}, d_ack, 1'b0);
    chk({tag, "_d_rdata"}, d_rdata, '0);
    chk({tag, "_d_err"}, d_err, 1'b0);
  endtask

  // Both ports request continuously for n_each transactions each; acks must alternate I,D,...
  task automatic tie_run(input logic [AW-1:0] ibase, input logic [AW-1:0] dbase, input int n_each);
    int ni, nd, k;
    int order[$];
    ni = 0; nd = 0; k = 0;
    ack_delay = 0;
    for (int j = 0; j < n_each; j++) begin
      grant_q.push_back(1'b0);
      grant_q.push_back(1'b1);
      push_exp(1'b0, model_rdata(ibase + 32'(4 * j)), 1'b0);
      push_exp(1'b1, model_rdata(dbase + 32'(4 * j)), 1'b0);
    end
    i_addr = ibase; d_addr = dbase; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
    while ((ni < n_each || nd < n_each) && k < 60) begin
      tick();
      k++;
      if (i_ack === 1'b1) begin
        order.push_back(0);
        ni++;
        if (ni < n_each) i_addr = ibase + 32'(4 * ni);
        else i_req = 1'b0;
      end
      if (d_ack === 1'b1) begin
        order.push_back(1);
        nd++;
        if (nd < n_each) d_addr = dbase + 32'(4 * nd);
        else d_req = 1'b0;
      end
    end
    chk("tie_ack_count", order.size(), 2 * n_each);
    for (int j = 0; j < order.size(); j++) chk($sformatf("tie_order_%0d", j), order[j], j % 2);
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  typedef struct {
    bit            port_d;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    int            exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int c0, at;
    ack_delay = v.delay;
    grant_q.push_back(v.port_d);
    push_exp(v.port_d, v.exp_rdata, v.exp_err);
    if (v.port_d) begin
      d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_req = 1'b1;
    end else begin
      i_addr = v.addr; i_req = 1'b1;
    end
    c0 = cyc;
    wait_ack(v.port_d, 40, at);
    chk($sformatf("vec%0d_latency", idx), 64'(at - c0), 64'(v.exp_lat));
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
  endtask

  vec_t vecs[7];
  vec_t vstray;

  initial begin
    int c0, at;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         0,  32'h2002_0001, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         1,  32'h2002_0141, 1'b0, 3};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2,  32'h2002_0141, 1'b0, 4};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0,         15, 32'h2002_1275, 1'b0, 17};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         16, 32'h0,         1'b1, 17};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,         -1, 32'h0,         1'b1, 17};
    vecs[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 0,  32'hDFFD_FFBD, 1'b0, 2};
    vstray  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         2,  32'h2002_0049, 1'b0, 4};

    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) tick();
    check_all_zero("in_reset");
    reset = 1'b0;
    tick();
    check_all_zero("after_reset");

    // First tie after reset goes to fetch, then strict alternation.
    tie_run(32'h10, 32'h20, 2);

    for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

    // Data access times out while a fetch waits; fetch is served right after the abort.
    ack_delay = -1;
    grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    push_exp(1'b1, '0, 1'b1);
    push_exp(1'b0, model_rdata(32'h44), 1'b0);
    d_we = 1'b0; d_addr = 32'h300; d_req = 1'b1;
    c0 = cyc;
    tick();
    i_addr = 32'h44; i_req = 1'b1;
    wait_ack(1'b1, 40, at);
    chk("timeout_latency", 64'(at - c0), 64'(TO + 1));
    d_req = 1'b0; ack_delay = 0; c0 = at;
    wait_ack(1'b0, 10, at);
    chk("pending_fetch_latency", 64'(at - c0), 64'd2);
    i_req = 1'b0;
    tick(); tick();

    // Reset in the middle of a fetch: everything clears, no ack, next tie favours fetch.
    ack_delay = -1;
    grant_q.push_back(1'b0);
    i_addr = 32'h50; i_req = 1'b1;
    tick(); tick();
    chk("busy_before_reset", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; i_req = 1'b0;
    check_all_zero("mid_reset");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_ack_after_abort", i_ack, 1'b0);
    end
    tie_run(32'h70, 32'h90, 1);

    // Fetch request still high during its ack cycle must not be granted again.
    ack_delay = 0;
    grant_q.push_back(1'b0);
    push_exp(1'b0, model_rdata(32'h60), 1'b0);
    i_addr = 32'h60; i_req = 1'b1;
    wait_ack(1'b0, 10, at);
    tick();
    chk("no_regrant_after_ack", mem_req, 1'b0);
    i_req = 1'b0;
    tick(); tick();

    // mem_ack while idle is ignored; a transaction still completes normally.
    stray_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stray_no_ack", i_ack | d_ack, 1'b0);
      chk("stray_no_req", mem_req, 1'b0);
    end
    run_vec(vstray, 7);
    stray_ack = 1'b0;
    tick(); tick();

    chk("scoreboard_i_empty", i_q.size(), 0);
    chk("scoreboard_d_empty", d_q.size(), 0);
    chk("scoreboard_grant_empty", grant_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected end before 10000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
